// File: rtl/wfg_record_spi.sv
// SPI slave receiver: oversamples SCLK/CS/SDI with clk, deserializes 8..32-bit frames, publishes AXI-Stream words.
// Optional saturating overrun counter enabled by WFG_RECORD_SPI_OVERRUN_CNT_EN.
module wfg_record_spi #(
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ctrl_en_q_i,
  input  logic                       cfg_cpha_q_i,
  input  logic                       cfg_cpol_q_i,
  input  logic                       cfg_lsbfirst_q_i,
  input  logic [1:0]                 cfg_dff_q_i,
  input  logic                       cfg_sspol_q_i,
  input  logic                       wfg_record_spi_sclk_i,
  input  logic                       wfg_record_spi_cs_ni,
  input  logic                       wfg_record_spi_sdi_i,
  output logic                       wfg_record_spi_tvalid_o,
  input  logic                       wfg_record_spi_tready_i,
  output logic [AXIS_DATA_WIDTH-1:0] wfg_record_spi_tdata_o,
  output logic                       wfg_record_spi_tlast_o,
  output logic                       wfg_record_spi_overrun_o
`ifdef WFG_RECORD_SPI_OVERRUN_CNT_EN
  ,
  output logic [15:0]                wfg_record_spi_overrun_cnt_o
`endif
);

  localparam int unsigned FRAME_W = 32;
  localparam int unsigned CNT_W   = 5;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync;
  logic                   sclk_d;
  logic                   sclk_s, cs_s, sdi_s;

  state_t             state, state_next;
  logic               cpha_q, cpol_q, lsb_q;
  logic [1:0]         dff_q;
  logic [CNT_W-1:0]   cnt, last_idx, bit_idx;
  logic [FRAME_W-1:0] shifter, staging, word_c;
  logic               staged;

  logic cs_act_c, rise_c, fall_c, edge_c;
  logic load_cfg_c, sample_c, done_c, clear_c, push_c, push_last_c;

  // Pin synchronizers; CS idles at the inactive level of an active-low select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      sdi_sync  <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], wfg_record_spi_sclk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], wfg_record_spi_cs_ni};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], wfg_record_spi_sdi_i};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign cs_act_c = (cs_s == cfg_sspol_q_i);
  assign rise_c   = sclk_s & ~sclk_d;
  assign fall_c   = ~sclk_s & sclk_d;
  assign edge_c   = (cpol_q ^ cpha_q) ? fall_c : rise_c;
  assign last_idx = {dff_q, 3'b111};
  assign bit_idx  = lsb_q ? cnt : (last_idx - cnt);
  assign word_c   = shifter | (FRAME_W'(sdi_s) << bit_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state plus datapath strobes
  always_comb begin
    state_next  = state;
    load_cfg_c  = 1'b0;
    sample_c    = 1'b0;
    done_c      = 1'b0;
    clear_c     = 1'b0;
    push_c      = 1'b0;
    push_last_c = 1'b0;
    if (!ctrl_en_q_i) begin
      state_next = IDLE;
      clear_c    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cs_act_c) begin
            state_next = SHIFT;
            load_cfg_c = 1'b1;
          end
        end
        SHIFT: begin
          if (!cs_act_c) begin
            state_next  = IDLE;
            clear_c     = 1'b1;
            push_c      = staged;
            push_last_c = 1'b1;
          end else if (edge_c) begin
            sample_c = 1'b1;
            if (cnt == last_idx) begin
              done_c = 1'b1;
              push_c = staged;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpha_q                   <= 1'b0;
      cpol_q                   <= 1'b0;
      lsb_q                    <= 1'b0;
      dff_q                    <= 2'b00;
      cnt                      <= '0;
      shifter                  <= '0;
      staging                  <= '0;
      staged                   <= 1'b0;
      wfg_record_spi_tvalid_o  <= 1'b0;
      wfg_record_spi_tdata_o   <= '0;
      wfg_record_spi_tlast_o   <= 1'b0;
      wfg_record_spi_overrun_o <= 1'b0;
    end else begin
      if (load_cfg_c) begin
        cpha_q <= cfg_cpha_q_i;
        cpol_q <= cfg_cpol_q_i;
        lsb_q  <= cfg_lsbfirst_q_i;
        dff_q  <= cfg_dff_q_i;
      end
      wfg_record_spi_overrun_o <= 1'b0;
      if (wfg_record_spi_tvalid_o && wfg_record_spi_tready_i) wfg_record_spi_tvalid_o <= 1'b0;
      // Staged word moves out only if the output slot is free this cycle
      if (push_c) begin
        if (!wfg_record_spi_tvalid_o || wfg_record_spi_tready_i) begin
          wfg_record_spi_tdata_o  <= AXIS_DATA_WIDTH'(staging);
          wfg_record_spi_tlast_o  <= push_last_c;
          wfg_record_spi_tvalid_o <= 1'b1;
        end else begin
          wfg_record_spi_overrun_o <= 1'b1;
        end
      end
      if (clear_c) begin
        cnt     <= '0;
        shifter <= '0;
        staged  <= 1'b0;
      end else if (sample_c) begin
        if (done_c) begin
          staging <= word_c;
          staged  <= 1'b1;
          cnt     <= '0;
          shifter <= '0;
        end else begin
          shifter <= word_c;
          cnt     <= cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef WFG_RECORD_SPI_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wfg_record_spi_overrun_cnt_o <= '0;
    else if (wfg_record_spi_overrun_o && (wfg_record_spi_overrun_cnt_o != 16'hFFFF))
      wfg_record_spi_overrun_cnt_o <= wfg_record_spi_overrun_cnt_o + 16'd1;
  end
`else
  // No overrun counter in this build; overrun_o remains the only indication.
`endif

endmodule

// File: tb/tb_wfg_record_spi.sv
// Self-checking bench for wfg_record_spi: directed scenarios plus randomized bursts vs a word-level model.
module tb_wfg_record_spi;
  localparam int HALF = 60;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, cpha, cpol, lsb, sspol;
  logic [1:0]  dff;
  logic        sclk, cs_n, sdi;
  logic        tvalid, tready, tlast, overrun;
  logic [31:0] tdata;
`ifdef WFG_RECORD_SPI_OVERRUN_CNT_EN
  logic [15:0] ovcnt;
`endif

  always #5 clk = ~clk;

  wfg_record_spi dut (
    .clk(clk), .rst_n(rst_n), .ctrl_en_q_i(en), .cfg_cpha_q_i(cpha), .cfg_cpol_q_i(cpol),
    .cfg_lsbfirst_q_i(lsb), .cfg_dff_q_i(dff), .cfg_sspol_q_i(sspol),
    .wfg_record_spi_sclk_i(sclk), .wfg_record_spi_cs_ni(cs_n), .wfg_record_spi_sdi_i(sdi),
    .wfg_record_spi_tvalid_o(tvalid), .wfg_record_spi_tready_i(tready),
    .wfg_record_spi_tdata_o(tdata), .wfg_record_spi_tlast_o(tlast),
    .wfg_record_spi_overrun_o(overrun)
`ifdef WFG_RECORD_SPI_OVERRUN_CNT_EN
    , .wfg_record_spi_overrun_cnt_o(ovcnt)
`endif
  );

  int total = 0;
  int bad = 0;
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  int ov_pulses = 0;
  logic hold_prev = 1'b0;
  logic [32:0] prev_word;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Collect accepted beats, overrun pulses, and verify the output stays put while stalled
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_prev) begin
        check("hold_valid", 64'(tvalid), 64'd1);
        check("hold_word", 64'({tlast, tdata}), 64'(prev_word));
      end
      if (tvalid && tready) got_q.push_back({tlast, tdata});
      if (overrun) ov_pulses++;
      hold_prev = tvalid && !tready;
      prev_word = {tlast, tdata};
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic set_cfg(input int mode, input int d, input logic l, input logic sp);
    cpol  = 1'(mode >> 1);
    cpha  = 1'(mode);
    dff   = 2'(d);
    lsb   = l;
    sspol = sp;
    sclk  = cpol;
    cs_n  = ~sp;
    repeat (10) @(negedge clk);
  endtask

  task automatic cs_begin();
    cs_n = sspol;
    #(HALF);
  endtask

  task automatic cs_end();
    #(HALF);
    cs_n = ~sspol;
    #(HALF * 2);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n_total, input int n_send);
    logic b;
    for (int i = 0; i < n_send; i++) begin
      b = lsb ? w[i] : w[n_total - 1 - i];
      if (!cpha) begin
        sdi = b; #(HALF); sclk = ~cpol; #(HALF); sclk = cpol;
      end else begin
        sclk = ~cpol; sdi = b; #(HALF); sclk = cpol; #(HALF);
      end
    end
  endtask

  task automatic compare(input string tag, input int exp_ov);
    int n;
    repeat (20) @(negedge clk);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(tag, 64'(got_q[i]), 64'(exp_q[i]));
    check({tag, "_ovr"}, 64'(ov_pulses), 64'(exp_ov));
    got_q.delete();
    exp_q.delete();
    ov_pulses = 0;
  endtask

  initial begin
    int mode, d, n, nb, part;
    logic [63:0] mask;
    logic [31:0] w;
    rst_n = 1'b0; en = 1'b1; tready = 1'b1; sdi = 1'b0;
    set_cfg(0, 0, 1'b0, 1'b0);
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Mode 0, 8-bit, MSB first
    cs_begin(); send_bits(32'hA5, 8, 8); cs_end();
    exp_q.push_back({1'b1, 32'h000000A5});
    compare("m0_a5", 0);

    // Mode 3, 16-bit, LSB first, two words
    set_cfg(3, 1, 1'b1, 1'b0);
    cs_begin(); send_bits(32'h1234, 16, 16); send_bits(32'hBEEF, 16, 16); cs_end();
    exp_q.push_back({1'b0, 32'h1234});
    exp_q.push_back({1'b1, 32'hBEEF});
    compare("m3_pair", 0);

    // Modes 1 and 2, 32-bit
    for (int m = 1; m <= 2; m++) begin
      set_cfg(m, 3, 1'b0, 1'b0);
      cs_begin(); send_bits(32'hDEADBEEF, 32, 32); cs_end();
      exp_q.push_back({1'b1, 32'hDEADBEEF});
      compare("m12_dead", 0);
    end

    // Stalled output: second word dropped, third survives
    set_cfg(0, 0, 1'b0, 1'b0);
    @(posedge clk); #1 tready = 1'b0;
    cs_begin();
    send_bits(32'h01, 8, 8); send_bits(32'h02, 8, 8); send_bits(32'h03, 8, 8);
    @(posedge clk); #1 tready = 1'b1;
    cs_end();
    exp_q.push_back({1'b0, 32'h01});
    exp_q.push_back({1'b1, 32'h03});
    compare("overrun", 1);
`ifdef WFG_RECORD_SPI_OVERRUN_CNT_EN
    check("ovcnt", 64'(ovcnt), 64'd1);
`endif

    // Partial frame dropped silently, next frame intact
    cs_begin(); send_bits(32'hFF, 8, 5); cs_end();
    cs_begin(); send_bits(32'h3C, 8, 8); cs_end();
    exp_q.push_back({1'b1, 32'h3C});
    compare("partial", 0);

    // Randomized bursts against the word-level model
    for (int it = 0; it < 10; it++) begin
      mode = int'($urandom_range(0, 3));
      d    = int'($urandom_range(0, 3));
      set_cfg(mode, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      nb   = 8 * (d + 1);
      mask = (64'd1 << nb) - 64'd1;
      n    = int'($urandom_range(1, 3));
      part = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, nb - 1)) : 0;
      cs_begin();
      for (int k = 0; k < n; k++) begin
        w = 32'($urandom) & mask[31:0];
        send_bits(w, nb, nb);
        exp_q.push_back({(k == n - 1), w});
      end
      if (part > 0) send_bits(32'($urandom), nb, part);
      cs_end();
      compare("rand", 0);
    end

    // Reset mid-frame with a word pending
    set_cfg(0, 0, 1'b0, 1'b0);
    @(posedge clk); #1 tready = 1'b0;
    cs_begin(); send_bits(32'h11, 8, 8); cs_end();
    repeat (5) @(negedge clk);
    check("pend_valid", 64'(tvalid), 64'd1);
    cs_begin(); send_bits(32'h22, 8, 4);
    #3 rst_n = 1'b0;
    #1;
    check("arst_tvalid", 64'(tvalid), 64'd0);
    check("arst_tdata", 64'(tdata), 64'd0);
    check("arst_tlast", 64'(tlast), 64'd0);
    check("arst_overrun", 64'(overrun), 64'd0);
`ifdef WFG_RECORD_SPI_OVERRUN_CNT_EN
    check("arst_ovcnt", 64'(ovcnt), 64'd0);
`endif
    cs_n = 1'b1;
    #(HALF * 2);
    rst_n = 1'b1;
    @(posedge clk); #1 tready = 1'b1;
    repeat (5) @(negedge clk);
    got_q.delete(); ov_pulses = 0;
    cs_begin(); send_bits(32'h55, 8, 8); cs_end();
    exp_q.push_back({1'b1, 32'h55});
    compare("post_rst", 0);

    // Disable mid-frame discards the partial word
    cs_begin(); send_bits(32'hAA, 8, 3);
    @(posedge clk); #1 en = 1'b0;
    repeat (5) @(negedge clk);
    cs_n = ~sspol;
    #(HALF * 2);
    en = 1'b1;
    repeat (5) @(negedge clk);
    cs_begin(); send_bits(32'h66, 8, 8); cs_end();
    exp_q.push_back({1'b1, 32'h66});
    compare("en_off", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wfg_record_spi.md
# wfg_record_spi

SPI slave receiver for the waveform generator: it monitors an external SPI bus (SCLK, CS, SDI) with the system clock and deserializes frames of 8/16/24/32 bits. It publishes each word on an AXI-Stream master interface with TLAST marking the final word of each chip-select burst. It is the receive-side counterpart of the SPI drive peripheral and shares its CPOL/CPHA/LSBFIRST/DFF/SSPOL register semantics, driven from its own wishbone register block.

## Interface
- AXIS_DATA_WIDTH, 32, AXI-Stream data width; must be >= 32; words are zero-extended.
- SYNC_STAGES, 2, synchronizer depth on SCLK/CS/SDI pins (>= 2).

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- ctrl_en_q_i  in  1  receiver enable.
- cfg_cpha_q_i  in  1  clock phase.
- cfg_cpol_q_i  in  1  clock idle level.
- cfg_lsbfirst_q_i  in  1  1 = LSB received first.
- cfg_dff_q_i  in  2  frame size: 00=8, 01=16, 10=24, 11=32 bits.
- cfg_sspol_q_i  in  1  chip-select active level (0 = active-low).
- wfg_record_spi_sclk_i  in  1  SPI clock pin (asynchronous).
- wfg_record_spi_cs_ni  in  1  chip-select pin (asynchronous).
- wfg_record_spi_sdi_i  in  1  serial data in (asynchronous).
- wfg_record_spi_tvalid_o  out  1  AXIS valid.
- wfg_record_spi_tready_i  in  1  AXIS ready.
- wfg_record_spi_tdata_o  out  AXIS_DATA_WIDTH  AXIS data.
- wfg_record_spi_tlast_o  out  1  last word of CS burst.
- wfg_record_spi_overrun_o  out  1  one-cycle pulse: word dropped.

## Operation
- SCLK, CS, SDI each pass a SYNC_STAGES flop chain; one extra SCLK flop provides edge detect.
- Sample edge: rising when cpol^cpha = 0, falling when cpol^cpha = 1.
- cpha/cpol/lsbfirst/dff latched on the clk cycle CS becomes active; changes mid-burst ignored.
- FSM: IDLE -> SHIFT when ctrl_en=1 and synced CS active; SHIFT -> IDLE on CS inactive or ctrl_en=0.
- SHIFT: each sample edge writes SDI to bit (lsbfirst ? cnt : N-1-cnt), cnt++. At cnt = N: word -> staging register (staged=1), cnt=0, shifter cleared.
- Staging -> output transfer: when a new word completes while staged=1 (tlast=0), or on CS deassert with staged=1 (tlast=1). Transfer allowed only if output empty or accepted same cycle (tvalid & tready); otherwise the staged word is discarded and overrun_o pulses. The new word still takes the staging slot.
- Partial frame (cnt != 0) at CS deassert or disable: discarded silently; no overrun.
- Output register holds tdata/tlast with tvalid=1 until tready; never changes while tvalid=1 & tready=0.
- ctrl_en=0: FSM to IDLE, shifter/counter/staging cleared; a pending output word remains until accepted.
- Reset values: tvalid_o=0, tdata_o=0, tlast_o=0, overrun_o=0; FSM IDLE, cnt=0, staged=0, synchronizers at 0 (CS sync resets to inactive level of sspol=0, i.e. 1).

## Timing
- Pin edge -> detected edge: SYNC_STAGES+1 clk cycles; SDI delayed identically, so sampling is aligned.
- SCLK high and low phases each >= SYNC_STAGES+2 clk periods; CS setup/hold to first/last SCLK edge >= same.
- Last bit edge detected -> word in staging: 1 cycle. CS-deassert detected -> tvalid_o=1 (output empty): 1 cycle.
- overrun_o asserted in the cycle the transfer would have occurred.
- Back-to-back tready=1: one word accepted per cycle; no bubbles beyond the above.

## Configuration
- WFG_RECORD_SPI_OVERRUN_CNT_EN defined: adds port wfg_record_spi_overrun_cnt_o out 16, increments on each overrun_o pulse, saturates at 0xFFFF, cleared only by rst_n.
- Undefined: port and counter absent; overrun_o still present.

## Test plan
- Mode 0, dff=00, MSB first, CS burst sending 0xA5 with tready=1 -> single word tdata=0x000000A5, tlast=1 after CS deassert, overrun_o never pulses.
- Mode 3, dff=01, LSB first, burst of 0x1234, 0xBEEF -> words 0x1234 (tlast=0) then 0xBEEF (tlast=1).
- Mode 1 and mode 2, dff=11, word 0xDEADBEEF -> tdata=0xDEADBEEF for both.
- tready=0, burst of three 8-bit words 0x01,0x02,0x03 -> output holds 0x01; 0x02 dropped with one overrun_o pulse; after tready=1 receive 0x01 then 0x03 (tlast=1); with macro, overrun_cnt_o=1.
- CS deasserted after 5 of 8 bits -> no tvalid, no overrun; next full 0x3C frame received correctly.
- Assert rst_n=0 mid-frame with tvalid=1 pending -> all outputs zero immediately; after release, a fresh 0x55 frame is received intact; ctrl_en=0 mid-frame likewise discards the partial frame.
